// File: rtl/bus_tg_pkg.sv
// rtl/bus_tg_pkg.sv - shared state encoding, LFSR constants and helpers for the bus traffic checker
package bus_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One step of the 16-bit Galois LFSR (right shift, taps XORed in on a 1 out).
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Width of the device-ID field; at least one bit so the slice is never empty.
  function automatic int dev_id_width(input int num_slaves);
    dev_id_width = (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

endpackage

// File: rtl/bus_traffic_checker_if.sv
// rtl/bus_traffic_checker_if.sv - device-side request bus between the checker and one master_port
// master: checker side (drives dvalid/dmode/daddr/dwdata, sees dready/s_ready/drdata)
// slave : bus side (the opposite directions)
interface bus_traffic_checker_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  dvalid;
  logic                  dmode;
  logic [ADDR_WIDTH-1:0] daddr;
  logic [DATA_WIDTH-1:0] dwdata;
  logic [DATA_WIDTH-1:0] drdata;
  logic                  dready;
  logic                  s_ready;

  modport master (
    output dvalid, dmode, daddr, dwdata,
    input  dready, s_ready, drdata
  );

  modport slave (
    input  dvalid, dmode, daddr, dwdata,
    output dready, s_ready, drdata
  );
endinterface

// File: rtl/bus_traffic_checker_lfsr16.sv
// rtl/bus_traffic_checker_lfsr16.sv - 16-bit Galois LFSR with seed load and 1-/2-step look-ahead
// clk, rst : clock, asynchronous active-high reset (state returns to SEED)
// load     : reload SEED (wins over adv2)
// adv2     : advance the register by two steps
// step1/2  : register value after one / two steps
module lfsr16
  import bus_tg_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv2,
  output logic [15:0] step1,
  output logic [15:0] step2
);
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    step1  = lfsr_next(lfsr_q);
    step2  = lfsr_next(step1);
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (adv2) begin
      lfsr_d = step2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end
endmodule

// File: rtl/bus_traffic_checker.sv
// rtl/bus_traffic_checker.sv - write-then-read-back bus traffic generator with error capture
// clk, rst   : clock, asynchronous active-high reset
// start      : begin a run (only honoured in IDLE/DONE)
// bus        : request bus, master side
// busy, done, pass, timeout : run status
// iter_count, err_count     : completed transactions, saturating mismatch count
// err_addr, err_exp, err_act: details of the first mismatch
module bus_traffic_checker
  import bus_tg_pkg::*;
#(
  parameter int          ADDR_WIDTH           = 16,
  parameter int          DATA_WIDTH           = 8,
  parameter int          SLAVE_MEM_ADDR_WIDTH = 12,
  parameter int          NUM_SLAVES           = 3,
  parameter int          NUM_ITER             = 10,
  parameter logic [15:0] LFSR_SEED            = 16'hACE1,
  parameter int          VALID_CYCLES         = 2,
  parameter int          SETTLE_CYCLES        = 2,
  parameter int          TIMEOUT              = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  bus_traffic_checker_if.master    bus,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [15:0]              iter_count,
  output logic [15:0]              err_count,
  output logic [ADDR_WIDTH-1:0]    err_addr,
  output logic [DATA_WIDTH-1:0]    err_exp,
  output logic [DATA_WIDTH-1:0]    err_act
);
  localparam int IDW = dev_id_width(NUM_SLAVES);

  state_e                state_q, state_d;
  logic                  phase_q, phase_d;     // 0: waiting for ready, 1: counting
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           to_q, to_d;
  logic                  dvalid_q, dvalid_d, dmode_q, dmode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, err_exp_q, err_exp_d, err_act_q, err_act_d;
  logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
  logic [15:0]           iter_q, iter_d, err_cnt_q, err_cnt_d;

  logic                  lfsr_load, lfsr_adv;
  logic [15:0]           l1, l2;
  logic [IDW-1:0]        gen_id;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic                  rdy, in_wait, is_wr;
  logic                  unused_lfsr_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .adv2  (lfsr_adv),
    .step1 (l1),
    .step2 (l2)
  );

  // Only part of each LFSR word becomes address/data.
  assign unused_lfsr_bits = ^{l1, l2};

  // Unpopulated device IDs fold onto slave 0.
  always_comb begin
    gen_id = l1[SLAVE_MEM_ADDR_WIDTH +: IDW];
    if (int'(gen_id) >= NUM_SLAVES) gen_id = '0;
    gen_addr = '0;
    gen_addr[SLAVE_MEM_ADDR_WIDTH-1:0]    = l1[SLAVE_MEM_ADDR_WIDTH-1:0];
    gen_addr[SLAVE_MEM_ADDR_WIDTH +: IDW] = gen_id;
  end

  assign rdy     = bus.dready & bus.s_ready;
  assign in_wait = (state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT) ||
                   (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);
  assign is_wr   = (state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    dvalid_d   = dvalid_q;
    dmode_d    = dmode_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    iter_d     = iter_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    err_exp_d  = err_exp_q;
    err_act_d  = err_act_q;
    lfsr_load  = 1'b0;
    lfsr_adv   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          lfsr_load  = 1'b1;
          iter_d     = '0;
          err_cnt_d  = '0;
          err_addr_d = '0;
          err_exp_d  = '0;
          err_act_d  = '0;
          timeout_d  = 1'b0;
          if (NUM_ITER == 0) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_GEN;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end
      end
      ST_GEN: begin
        lfsr_adv = 1'b1;
        addr_d   = gen_addr;
        wdata_d  = l2[DATA_WIDTH-1:0];
        state_d  = ST_WR_REQ;
      end
      ST_WR_REQ, ST_RD_REQ: begin
        if (!phase_q) begin
          if (rdy) begin
            phase_d  = 1'b1;
            dvalid_d = 1'b1;
            dmode_d  = is_wr;
            cnt_d    = 16'(VALID_CYCLES - 1);
          end
        end else if (cnt_q == '0) begin
          dvalid_d = 1'b0;
          dmode_d  = 1'b0;
          state_d  = is_wr ? ST_WR_WAIT : ST_RD_WAIT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_WR_WAIT, ST_RD_WAIT: begin
        if (!phase_q) begin
          if (rdy) begin
            if (SETTLE_CYCLES == 0) begin
              state_d = is_wr ? ST_RD_REQ : ST_CHECK;
            end else begin
              phase_d = 1'b1;
              cnt_d   = 16'(SETTLE_CYCLES - 1);
            end
          end
        end else if (cnt_q == '0) begin
          state_d = is_wr ? ST_RD_REQ : ST_CHECK;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_CHECK: begin
        if (bus.drdata != wdata_q) begin
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          if (err_cnt_q == '0) begin
            err_addr_d = addr_q;
            err_exp_d  = wdata_q;
            err_act_d  = bus.drdata;
          end
        end
        iter_d = iter_q + 16'd1;
        if (iter_d == 16'(NUM_ITER)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0) && !timeout_q;
        end else begin
          state_d = ST_GEN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort when a wait state has lasted TIMEOUT cycles without moving on.
    if (in_wait && (state_d == state_q) && (to_q == 16'(TIMEOUT - 1))) begin
      state_d   = ST_DONE;
      dvalid_d  = 1'b0;
      dmode_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      pass_d    = 1'b0;
      timeout_d = 1'b1;
    end

    // Timeout counter and phase restart on every state entry.
    if (state_d != state_q) begin
      to_d    = '0;
      phase_d = 1'b0;
    end else begin
      to_d = in_wait ? to_q + 16'd1 : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      to_q       <= '0;
      dvalid_q   <= 1'b0;
      dmode_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      iter_q     <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_act_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      dvalid_q   <= dvalid_d;
      dmode_q    <= dmode_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      iter_q     <= iter_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      err_exp_q  <= err_exp_d;
      err_act_q  <= err_act_d;
    end
  end

  assign bus.dvalid = dvalid_q;
  assign bus.dmode  = dmode_q;
  assign bus.daddr  = addr_q;
  assign bus.dwdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign iter_count = iter_q;
  assign err_count  = err_cnt_q;
  assign err_addr   = err_addr_q;
  assign err_exp    = err_exp_q;
  assign err_act    = err_act_q;
endmodule

// File: tb/tb_bus_traffic_checker.sv
// tb/tb_bus_traffic_checker.sv - scoreboard bench for bus_traffic_checker
module tb_bus_traffic_checker;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  bit   inv = 1'b0;
  bit   v1_seen = 1'b0;
  logic prev_v0 = 1'b0;
  int   compared = 0;
  int   mism = 0;
  exp_t exp_q[$];
  exp_t first_exp;
  logic [7:0] mem [0:65535];

  bus_traffic_checker_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bif0 ();
  bus_traffic_checker_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bif1 ();

  logic        busy0, done0, pass0, to0, busy1, done1, pass1, to1;
  logic [15:0] iter0, errc0, erra0, iter1, errc1, erra1;
  logic [7:0]  erre0, errac0, erre1, errac1;

  bus_traffic_checker u0 (
    .clk(clk), .rst(rst), .start(start0), .bus(bif0),
    .busy(busy0), .done(done0), .pass(pass0), .timeout(to0),
    .iter_count(iter0), .err_count(errc0), .err_addr(erra0),
    .err_exp(erre0), .err_act(errac0)
  );

  bus_traffic_checker #(.NUM_ITER(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .bus(bif1),
    .busy(busy1), .done(done1), .pass(pass1), .timeout(to1),
    .iter_count(iter1), .err_count(errc1), .err_addr(erra1),
    .err_exp(erre1), .err_act(errac1)
  );

  always #5 clk = ~clk;

  // Slave memory behind master_port 0; inv corrupts read bit 0.
  always @(posedge clk) begin
    if (bif0.dvalid) begin
      if (bif0.dmode) mem[bif0.daddr] <= bif0.dwdata;
      else            bif0.drdata <= mem[bif0.daddr] ^ {7'b0, inv};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] m_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic push_run();
    logic [15:0] l;
    logic [1:0]  id;
    exp_t        e;
    l = 16'hACE1;
    for (int i = 0; i < 10; i++) begin
      l  = m_next(l);
      id = l[13:12];
      if (id == 2'd3) id = 2'd0;
      e.addr = {2'b00, id, l[11:0]};
      l  = m_next(l);
      e.data = l[7:0];
      if (i == 0) first_exp = e;
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard: each write request start pops one expected address/data pair.
  always @(negedge clk) begin
    exp_t e;
    if (bif0.dvalid && !prev_v0 && bif0.dmode) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bif0.daddr), 32'(e.addr));
        check("wr_data", 32'(bif0.dwdata), 32'(e.data));
        check("wr_id_not_3", 32'(bif0.daddr[13:12] != 2'b11), 32'd1);
        check("wr_addr_hi", 32'(bif0.daddr[15:14]), 32'd0);
      end
    end
    prev_v0 = bif0.dvalid;
    if (bif1.dvalid) v1_seen = 1'b1;
  end

  task automatic pulse_start0();
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (!done0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bif0.dready  = 1'b1;
    bif0.s_ready = 1'b1;
    bif1.dready  = 1'b1;
    bif1.s_ready = 1'b1;
    bif1.drdata  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_pass", 32'(pass0), 32'd0);
    check("rst_timeout", 32'(to0), 32'd0);
    check("rst_dvalid", 32'(bif0.dvalid), 32'd0);
    check("rst_daddr", 32'(bif0.daddr), 32'd0);
    check("rst_iter", 32'(iter0), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean run, with start-latency checks and an ignored mid-run start
    push_run();
    pulse_start0();
    @(negedge clk);
    check("run_busy_after_start", 32'(busy0), 32'd1);
    check("run_dvalid_gen", 32'(bif0.dvalid), 32'd0);
    @(negedge clk);
    check("run_dvalid_wrreq_entry", 32'(bif0.dvalid), 32'd0);
    @(negedge clk);
    check("run_dvalid_rise", 32'(bif0.dvalid), 32'd1);
    check("run_dmode_write", 32'(bif0.dmode), 32'd1);
    repeat (20) @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    wait_done("run_done", 2000);
    check("run_pass", 32'(pass0), 32'd1);
    check("run_err_count", 32'(errc0), 32'd0);
    check("run_iter_count", 32'(iter0), 32'd10);
    check("run_busy_low", 32'(busy0), 32'd0);
    check("run_queue_empty", 32'(exp_q.size()), 32'd0);

    // Read data bit 0 inverted: every iteration mismatches
    inv = 1'b1;
    push_run();
    pulse_start0();
    @(negedge clk);
    wait_done("err_done", 2000);
    check("err_count", 32'(errc0), 32'd10);
    check("err_pass", 32'(pass0), 32'd0);
    check("err_addr", 32'(erra0), 32'(first_exp.addr));
    check("err_exp", 32'(erre0), 32'(first_exp.data));
    check("err_act", 32'(errac0), 32'(first_exp.data ^ 8'h01));
    inv = 1'b0;

    // dready held low: timeout 256 cycles after WR_REQ entry
    bif0.dready = 1'b0;
    pulse_start0();
    repeat (256) @(posedge clk);
    @(negedge clk);
    check("to_not_yet", 32'(to0), 32'd0);
    @(negedge clk);
    check("to_timeout", 32'(to0), 32'd1);
    check("to_done", 32'(done0), 32'd1);
    check("to_pass", 32'(pass0), 32'd0);
    check("to_dvalid", 32'(bif0.dvalid), 32'd0);
    check("to_busy", 32'(busy0), 32'd0);
    bif0.dready = 1'b1;

    // Reset during RD_WAIT of iteration 3, then replay from iteration 0
    push_run();
    pulse_start0();
    n = 0;
    while (iter0 != 16'd3 && n < 2000) begin @(negedge clk); n++; end
    check("rr_reach_iter3", 32'(iter0), 32'd3);
    n = 0;
    while (!(bif0.dvalid && !bif0.dmode) && n < 200) begin @(negedge clk); n++; end
    check("rr_read_seen", 32'(bif0.dvalid && !bif0.dmode), 32'd1);
    n = 0;
    while (bif0.dvalid && n < 200) begin @(negedge clk); n++; end
    check("rr_in_rd_wait", 32'(bif0.dvalid), 32'd0);
    rst = 1'b1;
    #1;
    check("rr_busy", 32'(busy0), 32'd0);
    check("rr_iter", 32'(iter0), 32'd0);
    check("rr_daddr", 32'(bif0.daddr), 32'd0);
    check("rr_dwdata", 32'(bif0.dwdata), 32'd0);
    check("rr_dmode", 32'(bif0.dmode), 32'd0);
    check("rr_done", 32'(done0), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    push_run();
    pulse_start0();
    @(negedge clk);
    check("rr_iter_restart", 32'(iter0), 32'd0);
    check("rr_busy_restart", 32'(busy0), 32'd1);
    wait_done("rr_done_replay", 2000);
    check("rr_iter_final", 32'(iter0), 32'd10);
    check("rr_pass_final", 32'(pass0), 32'd1);
    check("rr_queue_empty", 32'(exp_q.size()), 32'd0);

    // NUM_ITER = 0 instance
    v1_seen = 1'b0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    @(negedge clk);
    check("z_done", 32'(done1), 32'd1);
    check("z_pass", 32'(pass1), 32'd1);
    check("z_busy", 32'(busy1), 32'd0);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (5) @(negedge clk);
    check("z_done_again", 32'(done1), 32'd1);
    check("z_pass_again", 32'(pass1), 32'd1);
    check("z_iter", 32'(iter1), 32'd0);
    check("z_no_dvalid", 32'(v1_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
